// File: rtl/tt_sweep_capture.sv
// Exhaustive truth-table capture for a small combinational function with valid/ready hand-off.
// Define TT_SELFDUAL_EN to also register a self-duality flag alongside the captured table.
module tt_sweep_capture #(
    parameter int unsigned N_IN   = 7,
    parameter int unsigned SETTLE = 0,
    localparam int unsigned TT_W  = 2 ** N_IN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   x_out,
    input  logic              f_in,
    output logic              busy,
    output logic [TT_W-1:0]   tt,
    output logic [N_IN:0]     ones,
    output logic              tt_valid,
    input  logic              tt_ready,
    output logic              self_dual
);

    localparam int unsigned SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [N_IN:0]     ones_q, ones_d;
    logic              last_settle;
    logic              last_idx;

    assign last_settle = (settle_q == SW'(SETTLE));
    assign last_idx    = (idx_q == N_IN'(TT_W - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        tt_d     = tt_q;
        ones_d   = ones_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StSweep;
                    idx_d    = '0;
                    settle_d = '0;
                    tt_d     = '0;
                    ones_d   = '0;
                end
            end
            StSweep: begin
                if (last_settle) begin
                    tt_d[idx_q] = f_in;
                    ones_d      = ones_q + {{N_IN{1'b0}}, f_in};
                    settle_d    = '0;
                    // idx stays at TT_W-1 in DONE so x_out holds the last vector
                    if (last_idx) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + N_IN'(1);
                    end
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StDone: begin
                if (tt_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            settle_q <= '0;
            tt_q     <= '0;
            ones_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            tt_q     <= tt_d;
            ones_q   <= ones_d;
        end
    end

    assign x_out    = idx_q;
    assign tt       = tt_q;
    assign ones     = ones_q;
    assign busy     = (state_q == StSweep) || (state_q == StDone);
    assign tt_valid = (state_q == StDone);

`ifdef TT_SELFDUAL_EN
    logic sd_q, sd_d, sd_calc;

    // Evaluated on tt_d so the bit written on the final sweep edge is included.
    always_comb begin
        sd_calc = 1'b1;
        for (int i = 0; i < int'(TT_W); i++) begin
            if (tt_d[i] == tt_d[int'(TT_W) - 1 - i]) begin
                sd_calc = 1'b0;
            end
        end
    end

    always_comb begin
        sd_d = sd_q;
        if (state_q == StIdle && start) begin
            sd_d = 1'b0;
        end else if (state_q == StSweep && state_d == StDone) begin
            sd_d = sd_calc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sd_q <= 1'b0;
        end else begin
            sd_q <= sd_d;
        end
    end

    assign self_dual = sd_q;
`else
    assign self_dual = 1'b0;
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Randomized self-checking bench for tt_sweep_capture: two instances (SETTLE=0 and SETTLE=2)
// compared against a truth-table reference computed directly from the modelled FUT.
module tb_tt_sweep_capture;

`ifdef TT_SELFDUAL_EN
    localparam bit SD_EN = 1'b1;
`else
    localparam bit SD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start0, ready0, f0, busy0, valid0, sd0;
    logic [6:0]   x0;
    logic [127:0] tt0;
    logic [7:0]   ones0;
    logic         start2, ready2, f2, busy2, valid2, sd2;
    logic [6:0]   x2;
    logic [127:0] tt2;
    logic [7:0]   ones2;

    int           fsel;
    logic [127:0] rtbl;
    int           cur;
    int           n_tests = 0;
    int           n_fail  = 0;

    function automatic logic fut_eval(input int sel, input logic [6:0] x, input logic [127:0] tbl);
        case (sel)
            1:       return x[0];
            2:       return &x;
            3:       return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
            4:       return tbl[x];
            default: return 1'b0;
        endcase
    endfunction

    assign f0 = fut_eval(fsel, x0, rtbl);
    assign f2 = fut_eval(fsel, x2, rtbl);

    tt_sweep_capture #(.N_IN(7), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .x_out(x0), .f_in(f0), .busy(busy0),
        .tt(tt0), .ones(ones0), .tt_valid(valid0), .tt_ready(ready0), .self_dual(sd0)
    );

    tt_sweep_capture #(.N_IN(7), .SETTLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .x_out(x2), .f_in(f2), .busy(busy2),
        .tt(tt2), .ones(ones2), .tt_valid(valid2), .tt_ready(ready2), .self_dual(sd2)
    );

    logic         s_valid, s_busy, s_sd;
    logic [6:0]   s_x;
    logic [127:0] s_tt;
    logic [7:0]   s_ones;

    always_comb begin
        s_valid = valid0; s_busy = busy0; s_sd = sd0; s_x = x0; s_tt = tt0; s_ones = ones0;
        if (cur == 1) begin
            s_valid = valid2; s_busy = busy2; s_sd = sd2; s_x = x2; s_tt = tt2; s_ones = ones2;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        if (cur == 1) start2 = v;
        else          start0 = v;
    endtask

    task automatic drive_ready(input logic v);
        if (cur == 1) ready2 = v;
        else          ready0 = v;
    endtask

    task automatic build_expect(input int sel, output logic [127:0] etbl, output int eones,
                                output logic esd);
        logic sd;
        etbl = '0;
        for (int i = 0; i < 128; i++) etbl[i] = fut_eval(sel, 7'(i), rtbl);
        eones = $countones(etbl);
        // f(~x) == ~f(x); ~i over 7 bits is 127-i
        sd = 1'b1;
        for (int i = 0; i < 128; i++) if (etbl[i] == etbl[127 - i]) sd = 1'b0;
        esd = SD_EN && sd;
    endtask

    task automatic run_sweep(input int sel, input int settle, input bit noise, input int bp,
                             input bit start_on_hs);
        logic [127:0] etbl;
        int           eones;
        logic         esd;
        int           cycles;
        fsel = sel;
        build_expect(sel, etbl, eones, esd);
        drive_start(1'b1);
        @(posedge clk); #1;
        drive_start(1'b0);
        check_eq("busy_after_start", 128'(s_busy), 128'(1));
        check_eq("x_after_start", 128'(s_x), 128'(0));
        cycles = 0;
        while (!s_valid && cycles < 3000) begin
            if (noise) drive_start(logic'($urandom_range(0, 7) == 0));
            @(posedge clk); #1;
            cycles++;
        end
        drive_start(1'b0);
        check_eq("valid_latency", 128'(cycles), 128'(128 * (settle + 1)));
        check_eq("tt", s_tt, etbl);
        check_eq("ones", 128'(s_ones), 128'(eones));
        check_eq("self_dual", 128'(s_sd), 128'(esd));
        check_eq("x_in_done", 128'(s_x), 128'(127));
        for (int k = 0; k < bp; k++) begin
            drive_start(logic'($urandom_range(0, 1)));
            @(posedge clk); #1;
            check_eq("bp_valid", 128'(s_valid), 128'(1));
            check_eq("bp_tt", s_tt, etbl);
            check_eq("bp_ones", 128'(s_ones), 128'(eones));
        end
        drive_start(start_on_hs);
        drive_ready(1'b1);
        @(posedge clk); #1;
        drive_ready(1'b0);
        drive_start(1'b0);
        check_eq("hs_valid_drop", 128'(s_valid), 128'(0));
        check_eq("hs_busy_drop", 128'(s_busy), 128'(0));
        check_eq("idle_tt_held", s_tt, etbl);
        if (start_on_hs) begin
            @(posedge clk); #1;
            check_eq("hs_start_ignored", 128'(s_busy), 128'(0));
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start0 = 1'b0; ready0 = 1'b0; start2 = 1'b0; ready2 = 1'b0;
        cur = 0; fsel = 0; rtbl = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_x0", 128'(x0), 128'(0));
        check_eq("rst_tt0", tt0, 128'(0));
        check_eq("rst_ones0", 128'(ones0), 128'(0));
        check_eq("rst_busy0", 128'(busy0), 128'(0));
        check_eq("rst_valid0", 128'(valid0), 128'(0));
        check_eq("rst_sd0", 128'(sd0), 128'(0));
        check_eq("rst_valid2", 128'(valid2), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_sweep(0, 0, 1'b0, 0, 1'b0);
        run_sweep(1, 0, 1'b0, 0, 1'b0);
        run_sweep(2, 0, 1'b0, 0, 1'b0);
        cur = 1;
        run_sweep(3, 2, 1'b0, 0, 1'b0);
        cur = 0;
        rtbl = {$urandom, $urandom, $urandom, $urandom};
        run_sweep(4, 0, 1'b1, 10, 1'b1);

        // asynchronous reset in the middle of a sweep
        rtbl = {$urandom, $urandom, $urandom, $urandom};
        fsel = 4;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        n = 0;
        while (x0 != 7'd57 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("reach_idx57", 128'(x0), 128'(57));
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_x", 128'(x0), 128'(0));
        check_eq("mid_rst_tt", tt0, 128'(0));
        check_eq("mid_rst_ones", 128'(ones0), 128'(0));
        check_eq("mid_rst_busy", 128'(busy0), 128'(0));
        check_eq("mid_rst_valid", 128'(valid0), 128'(0));
        check_eq("mid_rst_sd", 128'(sd0), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_idle", 128'(busy0), 128'(0));
        run_sweep(4, 0, 1'b0, 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            rtbl = {$urandom, $urandom, $urandom, $urandom};
            // a random self-dual table on some rounds
            if (r == 1) for (int i = 0; i < 64; i++) rtbl[127 - i] = ~rtbl[i];
            run_sweep(4, 0, 1'b1, int'($urandom_range(0, 4)), 1'b0);
        end
        cur = 1;
        rtbl = {$urandom, $urandom, $urandom, $urandom};
        run_sweep(4, 2, 1'b1, 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
